issue_select: RTL and testbench
===============================

// Module: issue_select
// PURPOSE
//   Issue-queue select stage for the 16-entry CIQ. Tracks per-entry valid/FU/operand-ready state and
//   captures wake-up pulses. Each cycle it picks up to 2 ALU, 1 MUL and 1 LS ready entries and drives
//   the registered grant_*/addr_* buses. Those buses feed the tag broadcast and wake-up compare logic.
//   Tag storage stays in the CIQ RAM; dispatch writes tags at disp_idx.
// PARAMETERS
//   DEPTH      16  number of CIQ entries
//   IDX_W      5   width of addr_*/disp_idx; MSB always 0 for DEPTH=16
//   FU_W       2   FU class encoding width
// PORTS
//   clk            in   1        rising-edge clock
//   rst_n          in   1        synchronous active-low reset
//   flush          in   1        pipeline flush; squash all entries
//   disp_valid     in   1        dispatch request this cycle
//   disp_fu        in   FU_W     0=ALU 1=MUL 2=LS (3 reserved, treated as ALU)
//   disp_src1_rdy  in   1        src1 already ready at dispatch
//   disp_src2_rdy  in   1        src2 already ready at dispatch
//   disp_ready     out  1        at least one free entry (from registered valid)
//   disp_idx       out  IDX_W    lowest-index free entry; written when disp_valid&disp_ready
//   wk_prs1_rdy    in   DEPTH    src1 tag-match pulses from wake-up compare
//   wk_prs2_rdy    in   DEPTH    src2 tag-match pulses from wake-up compare
//   mul_busy       in   1        MUL unit cannot accept; suppress MUL select
//   entry_valid    out  DEPTH    registered per-entry valid
//   grant_alu0/grant_alu1/grant_mul/grant_ls   out  1      registered one-cycle issue grants
//   addr_alu0/addr_alu1/addr_mul/addr_ls       out  IDX_W  registered granted entry index
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): valid/r1/r2 all 0; all grants 0; all addr 0. disp_ready=1, disp_idx=0.
//   - Entry state per i: valid, fu, r1, r2. Dispatch sets valid=1, fu=disp_fu, r1/r2=disp_srcN_rdy.
//   - Wake-up: r1[i] <= r1[i] | (wk_prs1_rdy[i] & valid[i]), and likewise r2. Pulses to invalid entries are ignored.
//     A pulse in cycle c makes the entry requestable in c+1 and granted at the edge ending c+1.
//   - Request: req[i] = valid & r1 & r2, from registered bits only. No same-cycle wake-up-to-select bypass.
//   - Select: the ALU class takes the first and second priority entries (distinct) into alu0/alu1.
//     MUL takes one entry, only if !mul_busy; LS takes one entry.
//   - Grant latency: an entry dispatched ready at edge E0 is granted at edge E1 (grant high the cycle after).
//     At that same edge E1 the entry's valid clears.
//   - A grant is high for exactly one cycle per selection. addr_* holds its last value while its grant is 0.
//   - Free slot: disp_ready/disp_idx come from registered valid. An entry freed at edge E is reusable from
//     the cycle after E. A dispatch and an issue in the same cycle never collide.
//   - disp_valid while disp_ready=0: dropped, no state change.
//   - flush: at that edge, valid cleared and all grants forced to 0; addr_* hold. A dispatch in the flush cycle is dropped.
//     Flush has priority over wake-up, dispatch and select.
//   - Reset mid-operation overrides everything, including a pending grant.
// CONFIGURATION
//   ISSUE_AGE_MATRIX_EN defined:
//     - A DEPTHxDEPTH age matrix is maintained. On dispatch to k: age[k][j] <= valid[j] for all j
//       (k is younger than each j that is valid at that edge).
//     - Priority = oldest requesting entry. alu1 is the oldest after alu0's entry is masked out.
//     - Reset/flush clear the matrix.
//   ISSUE_AGE_MATRIX_EN undefined:
//     - Priority = lowest index. No matrix flops are built.
// STRUCTURE
//   - issue_pkg: FU_ALU/FU_MUL/FU_LS localparams, DEPTH, IDX_W, entry-state struct/typedef.
//   - Sub-module issue_pick (req[DEPTH], age matrix when enabled -> onehot grant + index).
//     Instances: alu0, alu1 (req masked by alu0 onehot), mul, ls.
// TESTING
//   1 rst_n=0 two cycles -> all grant_* 0, addr_* 0, entry_valid 0, disp_ready 1, disp_idx 0.
//   2 Dispatch ALU rdy/rdy into empty queue:
//       -> disp_idx=0; next cycle grant_alu0=1, addr_alu0=0, entry_valid[0]=0; grant drops the following cycle.
//   3 MUL entry at idx 3 with src1_rdy=0; pulse wk_prs1_rdy[3] in cycle c -> grant_mul=1, addr_mul=3 in c+2.
//       Repeat with mul_busy=1 held -> no grant until mul_busy=0.
//   4 ALU ready entries 2,5,9, index mode -> alu0=2, alu1=5, then alu0=9.
//       Age mode, dispatched in order 9,5,2 -> alu0=9, alu1=5, then alu0=2.
//   5 Dispatch 16 not-ready entries -> disp_ready=0; a 17th dispatch is dropped.
//       Wake entry 7 -> after its grant, disp_ready=1 and disp_idx=7.
//   6 flush asserted in the cycle where 4 entries are requestable -> next cycle all grants 0, entry_valid 0.
//       A wake-up pulse in that same cycle leaves no state.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the CIQ issue-select slice.
// FU class encodings, queue geometry and the per-entry state record.
package issue_pkg;

    localparam int DEPTH = 16;
    localparam int IDX_W = 5;
    localparam int FU_W  = 2;
    localparam int SEL_W = $clog2(DEPTH);

    localparam logic [FU_W-1:0] FU_ALU = 2'd0;
    localparam logic [FU_W-1:0] FU_MUL = 2'd1;
    localparam logic [FU_W-1:0] FU_LS  = 2'd2;
    localparam logic [FU_W-1:0] FU_RSV = 2'd3;

    typedef struct packed {
        logic            valid;
        logic [FU_W-1:0] fu;
        logic            r1;
        logic            r2;
    } entry_t;

    // The reserved encoding issues on an ALU port.
    function automatic logic is_alu(logic [FU_W-1:0] fu);
        return (fu == FU_ALU) || (fu == FU_RSV);
    endfunction

endpackage

// File: rtl/issue_select_if.sv
// Dispatch / wake-up / grant bundle of the issue-select stage.
// master: front end and wake-up logic; slave: issue_select.
interface issue_select_if;
    import issue_pkg::*;

    logic             flush;
    logic             disp_valid;
    logic [FU_W-1:0]  disp_fu;
    logic             disp_src1_rdy;
    logic             disp_src2_rdy;
    logic             disp_ready;
    logic [IDX_W-1:0] disp_idx;
    logic [DEPTH-1:0] wk_prs1_rdy;
    logic [DEPTH-1:0] wk_prs2_rdy;
    logic             mul_busy;
    logic [DEPTH-1:0] entry_valid;
    logic             grant_alu0;
    logic             grant_alu1;
    logic             grant_mul;
    logic             grant_ls;
    logic [IDX_W-1:0] addr_alu0;
    logic [IDX_W-1:0] addr_alu1;
    logic [IDX_W-1:0] addr_mul;
    logic [IDX_W-1:0] addr_ls;

    modport master (
        output flush, disp_valid, disp_fu, disp_src1_rdy, disp_src2_rdy,
        output wk_prs1_rdy, wk_prs2_rdy, mul_busy,
        input  disp_ready, disp_idx, entry_valid,
        input  grant_alu0, grant_alu1, grant_mul, grant_ls,
        input  addr_alu0, addr_alu1, addr_mul, addr_ls
    );

    modport slave (
        input  flush, disp_valid, disp_fu, disp_src1_rdy, disp_src2_rdy,
        input  wk_prs1_rdy, wk_prs2_rdy, mul_busy,
        output disp_ready, disp_idx, entry_valid,
        output grant_alu0, grant_alu1, grant_mul, grant_ls,
        output addr_alu0, addr_alu1, addr_mul, addr_ls
    );

endinterface

// File: rtl/issue_pick.sv
// Single-port picker: request vector -> one-hot grant + index.
// Ports: req_i, age_i (ISSUE_AGE_MATRIX_EN only), oh_o, idx_o, any_o.
module issue_pick
    import issue_pkg::*;
(
    input  logic [DEPTH-1:0]            req_i,
`ifdef ISSUE_AGE_MATRIX_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
`endif
    output logic [DEPTH-1:0]            oh_o,
    output logic [IDX_W-1:0]            idx_o,
    output logic                        any_o
);

    always_comb begin
        oh_o  = '0;
        idx_o = '0;
`ifdef ISSUE_AGE_MATRIX_EN
        // age_i[i][j]=1: i is younger than j. Oldest = no older requester.
        for (int i = 0; i < DEPTH; i++) begin
            oh_o[i] = req_i[i] & ~(|(req_i & age_i[i]));
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !(|oh_o)) begin
                oh_o[i] = 1'b1;
            end
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (oh_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
        any_o = |oh_o;
    end

endmodule

// File: rtl/issue_select.sv
// CIQ select stage: entry state, wake-up capture, 2xALU/MUL/LS pick.
// Ports: clk, rst_n (sync, low), io (issue_select_if.slave).
// Option: ISSUE_AGE_MATRIX_EN selects oldest-first instead of lowest-index.
module issue_select
    import issue_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    issue_select_if.slave io
);

    entry_t [DEPTH-1:0] ent_q, ent_d;

    logic [DEPTH-1:0] valid, req;
    logic [DEPTH-1:0] req_alu, req_alu1, req_mul, req_ls;
    logic [DEPTH-1:0] oh_a0, oh_a1, oh_m, oh_l, issued;
    logic [IDX_W-1:0] idx_a0, idx_a1, idx_m, idx_l;
    logic             any_a0, any_a1, any_m, any_l;
    logic [SEL_W-1:0] free_idx;
    logic             disp_rdy, do_disp;

    logic             g_a0_q, g_a1_q, g_m_q, g_l_q;
    logic [IDX_W-1:0] a_a0_q, a_a1_q, a_m_q, a_l_q;

`ifdef ISSUE_AGE_MATRIX_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
`endif

    always_comb begin
        valid   = '0;
        req     = '0;
        req_alu = '0;
        req_mul = '0;
        req_ls  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]   = ent_q[i].valid;
            req[i]     = ent_q[i].valid & ent_q[i].r1 & ent_q[i].r2;
            req_alu[i] = req[i] & is_alu(ent_q[i].fu);
            req_mul[i] = req[i] & (ent_q[i].fu == FU_MUL) & ~io.mul_busy;
            req_ls[i]  = req[i] & (ent_q[i].fu == FU_LS);
        end
    end

    // Second ALU port sees the requests left after the first pick.
    assign req_alu1 = req_alu & ~oh_a0;

`ifdef ISSUE_AGE_MATRIX_EN
    issue_pick u_alu0 (.req_i(req_alu),  .age_i(age_q), .oh_o(oh_a0), .idx_o(idx_a0), .any_o(any_a0));
    issue_pick u_alu1 (.req_i(req_alu1), .age_i(age_q), .oh_o(oh_a1), .idx_o(idx_a1), .any_o(any_a1));
    issue_pick u_mul  (.req_i(req_mul),  .age_i(age_q), .oh_o(oh_m),  .idx_o(idx_m),  .any_o(any_m));
    issue_pick u_ls   (.req_i(req_ls),   .age_i(age_q), .oh_o(oh_l),  .idx_o(idx_l),  .any_o(any_l));
`else
    issue_pick u_alu0 (.req_i(req_alu),  .oh_o(oh_a0), .idx_o(idx_a0), .any_o(any_a0));
    issue_pick u_alu1 (.req_i(req_alu1), .oh_o(oh_a1), .idx_o(idx_a1), .any_o(any_a1));
    issue_pick u_mul  (.req_i(req_mul),  .oh_o(oh_m),  .idx_o(idx_m),  .any_o(any_m));
    issue_pick u_ls   (.req_i(req_ls),   .oh_o(oh_l),  .idx_o(idx_l),  .any_o(any_l));
`endif

    assign issued = oh_a0 | oh_a1 | oh_m | oh_l;

    // Free slot from registered valid only, so it never collides with issue.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = SEL_W'(i);
            end
        end
    end

    assign disp_rdy = ~(&valid);
    assign do_disp  = io.disp_valid & disp_rdy;

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].r1    = ent_q[i].r1 | (io.wk_prs1_rdy[i] & ent_q[i].valid);
            ent_d[i].r2    = ent_q[i].r2 | (io.wk_prs2_rdy[i] & ent_q[i].valid);
            ent_d[i].valid = ent_q[i].valid & ~issued[i];
        end
        if (do_disp) begin
            ent_d[free_idx] = '{valid: 1'b1,
                                fu:    io.disp_fu,
                                r1:    io.disp_src1_rdy,
                                r2:    io.disp_src2_rdy};
        end
    end

`ifdef ISSUE_AGE_MATRIX_EN
    // New entry is younger than every live entry; nobody is younger than it.
    always_comb begin
        age_d = age_q;
        if (do_disp) begin
            age_d[free_idx] = valid;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][free_idx] = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q  <= '0;
            g_a0_q <= 1'b0;
            g_a1_q <= 1'b0;
            g_m_q  <= 1'b0;
            g_l_q  <= 1'b0;
            a_a0_q <= '0;
            a_a1_q <= '0;
            a_m_q  <= '0;
            a_l_q  <= '0;
`ifdef ISSUE_AGE_MATRIX_EN
            age_q  <= '0;
`endif
        end else if (io.flush) begin
            ent_q  <= '0;
            g_a0_q <= 1'b0;
            g_a1_q <= 1'b0;
            g_m_q  <= 1'b0;
            g_l_q  <= 1'b0;
`ifdef ISSUE_AGE_MATRIX_EN
            age_q  <= '0;
`endif
        end else begin
            ent_q  <= ent_d;
            g_a0_q <= any_a0;
            g_a1_q <= any_a1;
            g_m_q  <= any_m;
            g_l_q  <= any_l;
            if (any_a0) a_a0_q <= idx_a0;
            if (any_a1) a_a1_q <= idx_a1;
            if (any_m)  a_m_q  <= idx_m;
            if (any_l)  a_l_q  <= idx_l;
`ifdef ISSUE_AGE_MATRIX_EN
            age_q  <= age_d;
`endif
        end
    end

    assign io.disp_ready  = disp_rdy;
    assign io.disp_idx    = IDX_W'(free_idx);
    assign io.entry_valid = valid;
    assign io.grant_alu0  = g_a0_q;
    assign io.grant_alu1  = g_a1_q;
    assign io.grant_mul   = g_m_q;
    assign io.grant_ls    = g_l_q;
    assign io.addr_alu0   = a_a0_q;
    assign io.addr_alu1   = a_a1_q;
    assign io.addr_mul    = a_m_q;
    assign io.addr_ls     = a_l_q;

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed table, corner
// sequences and random traffic against an age/sequence-number model.
module tb_issue_select;
    import issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_select_if bus();

    issue_select dut (.clk(clk), .rst_n(rst_n), .io(bus));

    int checks = 0;
    int errors = 0;

    // Model: plain arrays, priority from dispatch sequence numbers.
    bit mv[DEPTH];
    int mfu[DEPTH];
    bit m1[DEPTH];
    bit m2[DEPTH];
    int mseq[DEPTH];
    int seqn = 0;
    bit eg[4];
    int ea[4];

    function automatic bit better(int a, int b);
`ifdef ISSUE_AGE_MATRIX_EN
        return mseq[a] < mseq[b];
`else
        return a < b;
`endif
    endfunction

    task automatic model_step();
        int a0, a1, mu, ls, fi, cls;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] = 0; m1[i] = 0; m2[i] = 0;
            end
            for (int k = 0; k < 4; k++) begin
                eg[k] = 0; ea[k] = 0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] = 0; m1[i] = 0; m2[i] = 0;
            end
            for (int k = 0; k < 4; k++) eg[k] = 0;
        end else begin
            a0 = -1; a1 = -1; mu = -1; ls = -1; fi = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (mv[i] && m1[i] && m2[i]) begin
                    cls = (mfu[i] == 1) ? 1 : (mfu[i] == 2) ? 2 : 0;
                    if (cls == 0) begin
                        if (a0 < 0 || better(i, a0)) begin
                            a1 = a0; a0 = i;
                        end else if (a1 < 0 || better(i, a1)) begin
                            a1 = i;
                        end
                    end else if (cls == 1) begin
                        if (!bus.mul_busy && (mu < 0 || better(i, mu))) mu = i;
                    end else begin
                        if (ls < 0 || better(i, ls)) ls = i;
                    end
                end
            end
            for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) fi = i;
            for (int i = 0; i < DEPTH; i++) begin
                m1[i] = m1[i] | (bus.wk_prs1_rdy[i] & mv[i]);
                m2[i] = m2[i] | (bus.wk_prs2_rdy[i] & mv[i]);
            end
            if (a0 >= 0) mv[a0] = 0;
            if (a1 >= 0) mv[a1] = 0;
            if (mu >= 0) mv[mu] = 0;
            if (ls >= 0) mv[ls] = 0;
            if (bus.disp_valid && fi >= 0) begin
                mv[fi] = 1; mfu[fi] = int'(bus.disp_fu);
                m1[fi] = bus.disp_src1_rdy; m2[fi] = bus.disp_src2_rdy;
                mseq[fi] = seqn; seqn++;
            end
            eg[0] = (a0 >= 0); if (a0 >= 0) ea[0] = a0;
            eg[1] = (a1 >= 0); if (a1 >= 0) ea[1] = a1;
            eg[2] = (mu >= 0); if (mu >= 0) ea[2] = mu;
            eg[3] = (ls >= 0); if (ls >= 0) ea[3] = ls;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] ev;
        int fi;
        ev = '0; fi = 0;
        for (int i = 0; i < DEPTH; i++) ev[i] = mv[i];
        for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) fi = i;
        chk("m_entry_valid", 32'(bus.entry_valid), 32'(ev));
        chk("m_disp_ready", 32'(bus.disp_ready), 32'(ev != 16'hFFFF));
        if (ev != 16'hFFFF) chk("m_disp_idx", 32'(bus.disp_idx), 32'(fi));
        chk("m_grant_alu0", 32'(bus.grant_alu0), 32'(eg[0]));
        chk("m_grant_alu1", 32'(bus.grant_alu1), 32'(eg[1]));
        chk("m_grant_mul", 32'(bus.grant_mul), 32'(eg[2]));
        chk("m_grant_ls", 32'(bus.grant_ls), 32'(eg[3]));
        chk("m_addr_alu0", 32'(bus.addr_alu0), 32'(ea[0]));
        chk("m_addr_alu1", 32'(bus.addr_alu1), 32'(ea[1]));
        chk("m_addr_mul", 32'(bus.addr_mul), 32'(ea[2]));
        chk("m_addr_ls", 32'(bus.addr_ls), 32'(ea[3]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_fu = '0;
        bus.disp_src1_rdy = 0; bus.disp_src2_rdy = 0;
        bus.wk_prs1_rdy = '0; bus.wk_prs2_rdy = '0;
    endtask

    task automatic disp(int fu, bit s1, bit s2);
        idle();
        bus.disp_valid = 1; bus.disp_fu = FU_W'(fu);
        bus.disp_src1_rdy = s1; bus.disp_src2_rdy = s2;
    endtask

    typedef struct {
        bit rst, fl, dv;
        bit [1:0] fu;
        bit s1, s2;
        bit [15:0] w1, w2;
        bit mb;
        bit [15:0] ev;
        bit dr;
        bit [4:0] di;
        bit ga0; bit [4:0] aa0;
        bit ga1; bit [4:0] aa1;
        bit gm;  bit [4:0] am;
        bit gl;  bit [4:0] al;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst_n = 0; bus.mul_busy = 0; idle();
        @(negedge clk);

        // rst fl dv fu s1 s2 w1 w2 mb | ev dr di ga0 aa0 ga1 aa1 gm am gl al
        tbl[0]  = '{0,0,0,0,0,0,16'h0,16'h0,0, 16'h0000,1,0, 0,0,0,0,0,0,0,0};
        tbl[1]  = '{0,0,0,0,0,0,16'h0,16'h0,0, 16'h0000,1,0, 0,0,0,0,0,0,0,0};
        tbl[2]  = '{1,0,1,0,1,1,16'h0,16'h0,0, 16'h0001,1,1, 0,0,0,0,0,0,0,0};
        tbl[3]  = '{1,0,0,0,0,0,16'h0,16'h0,0, 16'h0000,1,0, 1,0,0,0,0,0,0,0};
        tbl[4]  = '{1,0,1,0,0,1,16'h0,16'h0,0, 16'h0001,1,1, 0,0,0,0,0,0,0,0};
        tbl[5]  = '{1,0,1,0,0,1,16'h0,16'h0,0, 16'h0003,1,2, 0,0,0,0,0,0,0,0};
        tbl[6]  = '{1,0,1,0,0,1,16'h0,16'h0,0, 16'h0007,1,3, 0,0,0,0,0,0,0,0};
        tbl[7]  = '{1,0,1,1,0,1,16'h0,16'h0,0, 16'h000F,1,4, 0,0,0,0,0,0,0,0};
        tbl[8]  = '{1,0,0,0,0,0,16'h8,16'h0,0, 16'h000F,1,4, 0,0,0,0,0,0,0,0};
        tbl[9]  = '{1,0,0,0,0,0,16'h0,16'h0,0, 16'h0007,1,3, 0,0,0,0,1,3,0,0};
        tbl[10] = '{1,0,0,0,0,0,16'h0,16'h0,0, 16'h0007,1,3, 0,0,0,0,0,3,0,0};
        tbl[11] = '{1,0,1,2,1,1,16'h7,16'h0,0, 16'h000F,1,4, 0,0,0,0,0,3,0,0};
        tbl[12] = '{1,1,1,0,1,1,16'hFFFF,16'hFFFF,0, 16'h0000,1,0, 0,0,0,0,0,3,0,0};
        tbl[13] = '{1,0,1,0,0,1,16'h0,16'h0,0, 16'h0001,1,1, 0,0,0,0,0,3,0,0};
        tbl[14] = '{1,0,0,0,0,0,16'h0,16'h0,0, 16'h0001,1,1, 0,0,0,0,0,3,0,0};
        tbl[15] = '{1,1,0,0,0,0,16'h0,16'h0,0, 16'h0000,1,0, 0,0,0,0,0,3,0,0};

        for (int n = 0; n < 16; n++) begin
            rst_n = tbl[n].rst; bus.flush = tbl[n].fl;
            bus.disp_valid = tbl[n].dv; bus.disp_fu = tbl[n].fu;
            bus.disp_src1_rdy = tbl[n].s1; bus.disp_src2_rdy = tbl[n].s2;
            bus.wk_prs1_rdy = tbl[n].w1; bus.wk_prs2_rdy = tbl[n].w2;
            bus.mul_busy = tbl[n].mb;
            tick();
            chk($sformatf("t%0d_ev", n), 32'(bus.entry_valid), 32'(tbl[n].ev));
            chk($sformatf("t%0d_dr", n), 32'(bus.disp_ready), 32'(tbl[n].dr));
            chk($sformatf("t%0d_di", n), 32'(bus.disp_idx), 32'(tbl[n].di));
            chk($sformatf("t%0d_ga0", n), 32'(bus.grant_alu0), 32'(tbl[n].ga0));
            chk($sformatf("t%0d_aa0", n), 32'(bus.addr_alu0), 32'(tbl[n].aa0));
            chk($sformatf("t%0d_ga1", n), 32'(bus.grant_alu1), 32'(tbl[n].ga1));
            chk($sformatf("t%0d_aa1", n), 32'(bus.addr_alu1), 32'(tbl[n].aa1));
            chk($sformatf("t%0d_gm", n), 32'(bus.grant_mul), 32'(tbl[n].gm));
            chk($sformatf("t%0d_am", n), 32'(bus.addr_mul), 32'(tbl[n].am));
            chk($sformatf("t%0d_gl", n), 32'(bus.grant_ls), 32'(tbl[n].gl));
            chk($sformatf("t%0d_al", n), 32'(bus.addr_ls), 32'(tbl[n].al));
        end
        bus.mul_busy = 0; idle();

        // Priority: free 9, 5, 2 in that order and refill them with ALU ops.
        for (int k = 0; k < 10; k++) begin
            disp(2, 0, 0); tick();
        end
        foreach (tbl[p]) begin end
        for (int n = 0; n < 3; n++) begin
            int p;
            p = (n == 0) ? 9 : (n == 1) ? 5 : 2;
            idle(); bus.wk_prs1_rdy[p] = 1; bus.wk_prs2_rdy[p] = 1; tick();
            idle(); tick();
            chk("prio_ls_grant", 32'(bus.grant_ls), 32'd1);
            chk("prio_ls_addr", 32'(bus.addr_ls), 32'(p));
            chk("prio_free_idx", 32'(bus.disp_idx), 32'(p));
            disp(0, 0, 1); tick();
        end
        idle(); bus.wk_prs1_rdy = 16'h0224; tick();
        idle(); tick();
`ifdef ISSUE_AGE_MATRIX_EN
        chk("prio_a0_first", 32'(bus.addr_alu0), 32'd9);
        chk("prio_a1_first", 32'(bus.addr_alu1), 32'd5);
`else
        chk("prio_a0_first", 32'(bus.addr_alu0), 32'd2);
        chk("prio_a1_first", 32'(bus.addr_alu1), 32'd5);
`endif
        chk("prio_g0_first", 32'(bus.grant_alu0), 32'd1);
        chk("prio_g1_first", 32'(bus.grant_alu1), 32'd1);
        tick();
`ifdef ISSUE_AGE_MATRIX_EN
        chk("prio_a0_second", 32'(bus.addr_alu0), 32'd2);
`else
        chk("prio_a0_second", 32'(bus.addr_alu0), 32'd9);
`endif
        chk("prio_g1_second", 32'(bus.grant_alu1), 32'd0);
        idle(); bus.flush = 1; tick();

        // mul_busy holds a ready MUL entry back.
        bus.mul_busy = 1;
        disp(1, 0, 1); tick();
        idle(); bus.wk_prs1_rdy[0] = 1; tick();
        for (int k = 0; k < 4; k++) begin
            idle(); tick();
            chk("busy_no_grant", 32'(bus.grant_mul), 32'd0);
        end
        bus.mul_busy = 0; tick();
        chk("busy_release_grant", 32'(bus.grant_mul), 32'd1);
        chk("busy_release_addr", 32'(bus.addr_mul), 32'd0);
        idle(); bus.flush = 1; tick();

        // Full queue, dropped dispatch, slot reuse.
        for (int k = 0; k < 16; k++) begin
            disp(0, 0, 1); tick();
        end
        chk("full_not_ready", 32'(bus.disp_ready), 32'd0);
        disp(2, 1, 1); tick();
        chk("full_drop_valid", 32'(bus.entry_valid), 32'hFFFF);
        idle(); bus.wk_prs1_rdy[7] = 1; tick();
        idle(); tick();
        chk("full_grant7", 32'(bus.grant_alu0), 32'd1);
        chk("full_addr7", 32'(bus.addr_alu0), 32'd7);
        chk("full_reuse_rdy", 32'(bus.disp_ready), 32'd1);
        chk("full_reuse_idx", 32'(bus.disp_idx), 32'd7);
        idle(); bus.flush = 1; tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            bus.flush = ($urandom_range(0, 49) == 0);
            bus.disp_valid = ($urandom_range(0, 1) == 1);
            bus.disp_fu = FU_W'($urandom_range(0, 3));
            bus.disp_src1_rdy = ($urandom_range(0, 2) != 0);
            bus.disp_src2_rdy = ($urandom_range(0, 2) != 0);
            bus.wk_prs1_rdy = 16'($urandom) & 16'($urandom);
            bus.wk_prs2_rdy = 16'($urandom) & 16'($urandom);
            bus.mul_busy = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
